// File: rtl/pm_spm_pkg.sv
// rtl/pm_spm_pkg.sv - shared command/state encodings for the SPM page writer
package pm_spm_pkg;

    typedef enum logic [1:0] {
        CMD_FILL  = 2'd0,
        CMD_ERASE = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough for any word size; users take the low WORD_SIZE bits.
    localparam logic [63:0] ERASE_WORD = '1;

endpackage

// File: rtl/pm_spm_writer_if.sv
// rtl/pm_spm_writer_if.sv - CPU command side and PM write port of the SPM writer
interface pm_spm_writer_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13
);
    logic                 cmd_valid_i;
    logic [1:0]           cmd_i;
    logic [ADDR_W-1:0]    z_i;
    logic [WORD_SIZE-1:0] r_i;
    logic                 cmd_rdy_o;
    logic                 busy_o;
    logic                 stall_o;
    logic                 pm_sel_o;
    logic [ADDR_W-1:0]    pm_addr_o;
    logic                 pm_we_o;
    logic [WORD_SIZE-1:0] pm_data_o;
    logic                 done_o;
    logic                 err_o;

    modport slave (
        input  cmd_valid_i, cmd_i, z_i, r_i,
        output cmd_rdy_o, busy_o, stall_o, pm_sel_o, pm_addr_o, pm_we_o,
               pm_data_o, done_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_i, z_i, r_i,
        input  cmd_rdy_o, busy_o, stall_o, pm_sel_o, pm_addr_o, pm_we_o,
               pm_data_o, done_o, err_o
    );
endinterface

// File: rtl/pm_page_buf.sv
// rtl/pm_page_buf.sv - one-page temporary buffer: single write port, async read, clear-all
module pm_page_buf #(
    parameter int WORD_SIZE = 16,
    parameter int PAGE_W    = 5
) (
    input  logic                 clk_i,
    input  logic                 i_clr,
    input  logic                 i_we,
    input  logic [PAGE_W-1:0]    i_widx,
    input  logic [WORD_SIZE-1:0] i_wdata,
    input  logic [PAGE_W-1:0]    i_ridx,
    output logic [WORD_SIZE-1:0] o_rdata
);
    localparam int PAGE_WORDS = 2 ** PAGE_W;

    logic [WORD_SIZE-1:0] r_mem [PAGE_WORDS];

    always_ff @(posedge clk_i) begin
        if (i_clr) begin
            for (int i = 0; i < PAGE_WORDS; i++) begin
                r_mem[i] <= '1;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/pm_spm_writer.sv
// rtl/pm_spm_writer.sv - SPM page erase/write engine; PM_WRITE_PROTECT_EN guards the boot section
module pm_spm_writer
    import pm_spm_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_W     = 13,
    parameter int PAGE_W     = 5,
    parameter int BOOT_START = 7936
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pm_spm_writer_if.slave   bus
);
    localparam logic [WORD_SIZE-1:0] ERASE_DATA = ERASE_WORD[WORD_SIZE-1:0];

    state_e                      r_state;
    logic [PAGE_W-1:0]           r_cnt;
    logic [ADDR_W-PAGE_W-1:0]    r_page;
    logic                        r_sel;
    logic                        r_we;
    logic                        r_done;
    logic [ADDR_W-1:0]           r_addr;
    logic [WORD_SIZE-1:0]        r_data;

    cmd_e                        w_cmd;
    logic                        w_accept;
    logic                        w_page_op;
    logic                        w_protected;
    logic                        w_start;
    logic                        w_last;
    logic [PAGE_W-1:0]           w_next_cnt;
    logic [PAGE_W-1:0]           w_rd_idx;
    logic [WORD_SIZE-1:0]        w_rd_data;
    logic [ADDR_W-PAGE_W-1:0]    w_page;
    logic                        w_fill;
    logic                        w_clr;

    assign w_cmd      = cmd_e'(bus.cmd_i);
    assign w_accept   = bus.cmd_valid_i && (r_state == ST_IDLE);
    assign w_page_op  = w_accept && ((w_cmd == CMD_ERASE) || (w_cmd == CMD_WRITE));
    assign w_start    = w_page_op && !w_protected;
    assign w_page     = bus.z_i[ADDR_W-1:PAGE_W];
    assign w_last     = (r_cnt == '1);
    assign w_next_cnt = r_cnt + 1'b1;
    // Outputs are registered one word ahead, so the buffer is read at the next index.
    assign w_rd_idx   = (r_state == ST_IDLE) ? '0 : w_next_cnt;
    assign w_fill     = w_accept && (w_cmd == CMD_FILL);
    assign w_clr      = rst_i || (w_accept && (w_cmd == CMD_CLEAR))
                      || ((r_state == ST_WRITE) && w_last);

    pm_page_buf #(
        .WORD_SIZE (WORD_SIZE),
        .PAGE_W    (PAGE_W)
    ) u_buf (
        .clk_i   (clk_i),
        .i_clr   (w_clr),
        .i_we    (w_fill),
        .i_widx  (bus.z_i[PAGE_W-1:0]),
        .i_wdata (bus.r_i),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_page  <= '0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= (w_cmd == CMD_ERASE) ? ST_ERASE : ST_WRITE;
                        r_page  <= w_page;
                        r_cnt   <= '0;
                        r_sel   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= {w_page, {PAGE_W{1'b0}}};
                        r_data  <= (w_cmd == CMD_ERASE) ? ERASE_DATA : w_rd_data;
                    end
                end
                ST_ERASE, ST_WRITE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_sel   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt  <= w_next_cnt;
                        r_addr <= {r_page, w_next_cnt};
                        r_data <= (r_state == ST_ERASE) ? ERASE_DATA : w_rd_data;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PM_WRITE_PROTECT_EN
    logic r_err;

    assign w_protected = (int'({w_page, {PAGE_W{1'b0}}}) >= BOOT_START);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_page_op && w_protected;
        end
    end

    assign bus.err_o = r_err;
`else
    // No boot section exists without protection; BOOT_START can never be negative.
    assign w_protected = (BOOT_START < 0);
    assign bus.err_o   = 1'b0;
`endif

    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.stall_o   = (r_state != ST_IDLE);
    assign bus.cmd_rdy_o = (r_state == ST_IDLE);
    assign bus.pm_sel_o  = r_sel;
    assign bus.pm_we_o   = r_we;
    assign bus.pm_addr_o = r_addr;
    assign bus.pm_data_o = r_data;
    assign bus.done_o    = r_done;
endmodule

// File: tb/tb_pm_spm_writer.sv
// tb/tb_pm_spm_writer.sv - directed self-checking bench for pm_spm_writer
module tb_pm_spm_writer;
    import pm_spm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pm_spm_writer_if #(.WORD_SIZE(16), .ADDR_W(13)) bus ();

    pm_spm_writer #(
        .WORD_SIZE (16),
        .ADDR_W    (13),
        .PAGE_W    (5),
        .BOOT_START(7936)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        c_we   [64];
    logic        c_sel  [64];
    logic        c_busy [64];
    logic        c_stall[64];
    logic        c_done [64];
    logic        c_err  [64];
    logic        c_rdy  [64];
    logic [12:0] c_addr [64];
    logic [15:0] c_data [64];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_e cmd, input logic [12:0] z, input logic [15:0] r);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = cmd;
        bus.z_i         = z;
        bus.r_i         = r;
        step();
        bus.cmd_valid_i = 1'b0;
    endtask

    // Records n cycles starting with the current one; optionally strobes a command at index inj.
    task automatic capture(input int n, input int inj, input cmd_e icmd, input logic [12:0] iz);
        for (int i = 0; i < n; i++) begin
            c_we[i]    = bus.pm_we_o;
            c_sel[i]   = bus.pm_sel_o;
            c_busy[i]  = bus.busy_o;
            c_stall[i] = bus.stall_o;
            c_done[i]  = bus.done_o;
            c_err[i]   = bus.err_o;
            c_rdy[i]   = bus.cmd_rdy_o;
            c_addr[i]  = bus.pm_addr_o;
            c_data[i]  = bus.pm_data_o;
            if (i == inj) begin
                bus.cmd_valid_i = 1'b1;
                bus.cmd_i       = icmd;
                bus.z_i         = iz;
            end
            step();
            bus.cmd_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.cmd_rdy_o, bus.busy_o, bus.stall_o, bus.pm_sel_o, bus.pm_we_o, bus.done_o, bus.err_o}
                !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_flags: got rdy/busy/stall/sel/we/done/err=%b want 1000000",
                     {bus.cmd_rdy_o, bus.busy_o, bus.stall_o, bus.pm_sel_o, bus.pm_we_o, bus.done_o, bus.err_o});
        end
        n_checks++;
        if ({bus.pm_addr_o, bus.pm_data_o} !== 29'h0) begin
            n_errors++;
            $display("FAIL reset_bus: got addr=%h data=%h want 0/0", bus.pm_addr_o, bus.pm_data_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_write();
        int n_done;
        for (int i = 0; i < 32; i++) begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_i       = CMD_FILL;
            bus.z_i         = 13'h0040 + 13'(i);
            bus.r_i         = 16'h1000 + 16'(i);
            step();
        end
        bus.cmd_valid_i = 1'b0;
        send(CMD_WRITE, 13'h0045, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if ({c_we[k], c_sel[k], c_addr[k], c_data[k]} !== {2'b11, 13'h0040 + 13'(k), 16'h1000 + 16'(k)}) begin
                n_errors++;
                $display("FAIL write_word[%0d]: got we=%b sel=%b addr=%h data=%h want 1 1 %h %h",
                         k, c_we[k], c_sel[k], c_addr[k], c_data[k], 13'h0040 + 13'(k), 16'h1000 + 16'(k));
            end
        end
        n_checks++;
        if ({c_done[32], c_we[32], c_sel[32], c_busy[32], c_addr[32], c_data[32]} !== {4'b1001, 13'h005F, 16'h101F}) begin
            n_errors++;
            $display("FAIL write_done_cycle: got done=%b we=%b sel=%b busy=%b addr=%h data=%h want 1 0 0 1 005f 101f",
                     c_done[32], c_we[32], c_sel[32], c_busy[32], c_addr[32], c_data[32]);
        end
        n_checks++;
        if ({c_rdy[33], c_busy[33], c_done[33]} !== 3'b100) begin
            n_errors++;
            $display("FAIL write_idle_after: got rdy/busy/done=%b want 100", {c_rdy[33], c_busy[33], c_done[33]});
        end
        n_done = 0;
        for (int k = 0; k < 34; k++) n_done += int'(c_done[k]);
        n_checks++;
        if (n_done != 1) begin
            n_errors++;
            $display("FAIL write_done_count: got %0d want 1", n_done);
        end
        send(CMD_WRITE, 13'h0100, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if ({c_we[k], c_addr[k], c_data[k]} !== {1'b1, 13'h0100 + 13'(k), 16'hFFFF}) begin
                n_errors++;
                $display("FAIL autoclear[%0d]: got we=%b addr=%h data=%h want 1 %h ffff",
                         k, c_we[k], c_addr[k], c_data[k], 13'h0100 + 13'(k));
            end
        end
    endtask

    task automatic test_erase();
        int n_busy, n_stall, n_we;
        send(CMD_ERASE, 13'h1234, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        n_busy = 0; n_stall = 0; n_we = 0;
        for (int k = 0; k < 34; k++) begin
            n_busy  += int'(c_busy[k]);
            n_stall += int'(c_stall[k]);
            n_we    += int'(c_we[k]);
        end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if ({c_we[k], c_addr[k], c_data[k]} !== {1'b1, 13'h1220 + 13'(k), 16'hFFFF}) begin
                n_errors++;
                $display("FAIL erase_word[%0d]: got we=%b addr=%h data=%h want 1 %h ffff",
                         k, c_we[k], c_addr[k], c_data[k], 13'h1220 + 13'(k));
            end
        end
        n_checks++;
        if (n_busy != 33 || n_stall != 33 || n_we != 32) begin
            n_errors++;
            $display("FAIL erase_counts: got busy=%0d stall=%0d we=%0d want 33 33 32", n_busy, n_stall, n_we);
        end
    endtask

    task automatic test_cmd_while_busy();
        int n_we, n_err, n_bad;
        send(CMD_ERASE, 13'h0080, 16'h0);
        capture(40, 4, CMD_WRITE, 13'h0300);
        n_we = 0; n_err = 0; n_bad = 0;
        for (int k = 0; k < 40; k++) begin
            n_we  += int'(c_we[k]);
            n_err += int'(c_err[k]);
            if (c_we[k] && (c_addr[k][12:5] != 8'h04 || c_data[k] != 16'hFFFF)) n_bad++;
        end
        n_checks++;
        if (n_we != 32 || n_err != 0 || n_bad != 0) begin
            n_errors++;
            $display("FAIL busy_ignore: got we=%0d err=%0d off_page=%0d want 32 0 0", n_we, n_err, n_bad);
        end
    endtask

    task automatic test_reset_mid();
        int n_we, n_done;
        for (int i = 0; i < 4; i++) send(CMD_FILL, 13'(i), 16'hABC0 + 16'(i));
        send(CMD_WRITE, 13'h0200, 16'h0);
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if ({bus.pm_we_o, bus.pm_addr_o} !== {1'b1, 13'h0209}) begin
            n_errors++;
            $display("FAIL mid_cycle10: got we=%b addr=%h want 1 0209", bus.pm_we_o, bus.pm_addr_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.pm_we_o, bus.pm_sel_o, bus.cmd_rdy_o, bus.done_o} !== 4'b0010) begin
            n_errors++;
            $display("FAIL mid_reset: got we/sel/rdy/done=%b want 0010",
                     {bus.pm_we_o, bus.pm_sel_o, bus.cmd_rdy_o, bus.done_o});
        end
        capture(40, -1, CMD_FILL, 13'h0);
        n_we = 0; n_done = 0;
        for (int k = 0; k < 40; k++) begin
            n_we   += int'(c_we[k]);
            n_done += int'(c_done[k]);
        end
        n_checks++;
        if (n_we != 0 || n_done != 0) begin
            n_errors++;
            $display("FAIL mid_quiet: got we=%0d done=%0d want 0 0", n_we, n_done);
        end
        send(CMD_WRITE, 13'h0200, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if ({c_we[k], c_addr[k], c_data[k]} !== {1'b1, 13'h0200 + 13'(k), 16'hFFFF}) begin
                n_errors++;
                $display("FAIL mid_rewrite[%0d]: got we=%b addr=%h data=%h want 1 %h ffff",
                         k, c_we[k], c_addr[k], c_data[k], 13'h0200 + 13'(k));
            end
        end
    endtask

    task automatic test_top_page();
        logic [15:0] ed;
        send(CMD_FILL, 13'h1FFF, 16'h5A5A);
        send(CMD_WRITE, 13'h1FFF, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            ed = (k == 31) ? 16'h5A5A : 16'hFFFF;
            n_checks++;
            if ({c_we[k], c_addr[k], c_data[k]} !== {1'b1, 13'h1FE0 + 13'(k), ed}) begin
                n_errors++;
                $display("FAIL top_page[%0d]: got we=%b addr=%h data=%h want 1 %h %h",
                         k, c_we[k], c_addr[k], c_data[k], 13'h1FE0 + 13'(k), ed);
            end
        end
        n_checks++;
        if ({c_we[32], c_addr[32]} !== {1'b0, 13'h1FFF}) begin
            n_errors++;
            $display("FAIL top_no_wrap: got we=%b addr=%h want 0 1fff", c_we[32], c_addr[32]);
        end
    endtask

    task automatic test_fill_clear();
        logic [15:0] ed;
        send(CMD_FILL, 13'h0305, 16'h1111);
        send(CMD_FILL, 13'h0305, 16'h2222);
        send(CMD_FILL, 13'h0306, 16'h3333);
        send(CMD_WRITE, 13'h0300, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            ed = (k == 5) ? 16'h2222 : (k == 6) ? 16'h3333 : 16'hFFFF;
            n_checks++;
            if (c_data[k] !== ed) begin
                n_errors++;
                $display("FAIL overwrite[%0d]: got data=%h want %h", k, c_data[k], ed);
            end
        end
        send(CMD_FILL, 13'h0007, 16'h7777);
        send(CMD_CLEAR, 13'h0000, 16'h0);
        send(CMD_WRITE, 13'h0300, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (c_data[k] !== 16'hFFFF) begin
                n_errors++;
                $display("FAIL clear[%0d]: got data=%h want ffff", k, c_data[k]);
            end
        end
    endtask

    task automatic test_protect();
        int n_we, n_busy, n_err;
        logic [15:0] ed;
        send(CMD_FILL, 13'h0002, 16'h1234);
        send(CMD_ERASE, 13'h1F00, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        n_we = 0; n_busy = 0; n_err = 0;
        for (int k = 0; k < 34; k++) begin
            n_we   += int'(c_we[k]);
            n_busy += int'(c_busy[k]);
            n_err  += int'(c_err[k]);
        end
`ifdef PM_WRITE_PROTECT_EN
        n_checks++;
        if (c_err[0] !== 1'b1 || n_err != 1 || n_we != 0 || n_busy != 0) begin
            n_errors++;
            $display("FAIL protect: got err0=%b err=%0d we=%0d busy=%0d want 1 1 0 0",
                     c_err[0], n_err, n_we, n_busy);
        end
`else
        n_checks++;
        if (n_err != 0 || n_we != 32 || n_busy != 33 || c_addr[0] !== 13'h1F00 || c_addr[31] !== 13'h1F1F) begin
            n_errors++;
            $display("FAIL unprotected: got err=%0d we=%0d busy=%0d a0=%h a31=%h want 0 32 33 1f00 1f1f",
                     n_err, n_we, n_busy, c_addr[0], c_addr[31]);
        end
`endif
        send(CMD_WRITE, 13'h0000, 16'h0);
        capture(34, -1, CMD_FILL, 13'h0);
        for (int k = 0; k < 32; k++) begin
            ed = (k == 2) ? 16'h1234 : 16'hFFFF;
            n_checks++;
            if (c_data[k] !== ed) begin
                n_errors++;
                $display("FAIL protect_buf[%0d]: got data=%h want %h", k, c_data[k], ed);
            end
        end
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 2'd0;
        bus.z_i         = '0;
        bus.r_i         = '0;
        test_reset();
        test_fill_write();
        test_erase();
        test_cmd_while_busy();
        test_reset_mid();
        test_top_page();
        test_fill_clear();
        test_protect();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
